// File: rtl/frog_scene_gen_if.sv
// Pixel request/response bus between vga_driver (master) and a scene generator (slave).
// The driver presents the coordinates of the next pixel; the scene returns its color one cycle later.
interface frog_scene_gen_if;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic [7:0] color_in;

    modport master (output next_x, output next_y, input color_in);
    modport slave  (input next_x, input next_y, output color_in);
endinterface

// File: rtl/frog_scene_gen.sv
// Frogger-style scene source: lane background, a frog tile moved one hop per button press at
// vblank, and a win counter.
module frog_scene_gen #(
    parameter int         TILE_SHIFT = 5,
    parameter int         COLS       = 20,
    parameter int         ROWS       = 15,
    parameter int         START_COL  = 9,
    parameter int         START_ROW  = 14,
    parameter int         INSET      = 4,
    parameter logic [7:0] FROG_COLOR = 8'b11111100
) (
    input  logic             clk_25M,
    input  logic             reset,
    frog_scene_gen_if.slave  pix,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    output logic [4:0]       frog_col,
    output logic [3:0]       frog_row,
    output logic             win,
    output logic [3:0]       score
);
    localparam int TILE     = 1 << TILE_SHIFT;
    localparam int H_ACTIVE = COLS << TILE_SHIFT;
    localparam int V_ACTIVE = ROWS << TILE_SHIFT;

    localparam logic [7:0] GOAL_COLOR   = 8'b00011100;
    localparam logic [7:0] WATER_COLOR  = 8'b00000011;
    localparam logic [7:0] MEDIAN_COLOR = 8'b00010100;
    localparam logic [7:0] ROAD_COLOR   = 8'b01001001;
    localparam logic [7:0] START_COLOR  = 8'b00010100;

    typedef enum logic {IDLE, WAIT_REL} state_t;

    state_t     state;
    logic       win_pending;
    logic       frame_tick;
    logic [3:0] btn_meta;   // {up, down, left, right}
    logic [3:0] btn_sync;
    logic       any_btn;
    logic [4:0] hop_col;
    logic [3:0] hop_row;
    logic [7:0] color_next;

    logic [9:0] tile_x, tile_y, off_x, off_y;
    logic       frog_hit;

    assign any_btn = |btn_sync;

    // Clamped single-axis hop; priority up > down > left > right.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hop_col = frog_col;
        hop_row = frog_row;
        if (btn_sync[3]) begin
            if (frog_row != 4'd0) hop_row = frog_row - 4'd1;
        end else if (btn_sync[2]) begin
            if (frog_row != 4'(ROWS - 1)) hop_row = frog_row + 4'd1;
        end else if (btn_sync[1]) begin
            if (frog_col != 5'd0) hop_col = frog_col - 5'd1;
        end else if (btn_sync[0]) begin
            if (frog_col != 5'(COLS - 1)) hop_col = frog_col + 5'd1;
        end
    end

    always_comb begin
        tile_x   = pix.next_x >> TILE_SHIFT;
        tile_y   = pix.next_y >> TILE_SHIFT;
        off_x    = pix.next_x & 10'(TILE - 1);
        off_y    = pix.next_y & 10'(TILE - 1);
        frog_hit = (tile_x == 10'(frog_col)) && (tile_y == 10'(frog_row)) &&
                   (off_x >= 10'(INSET)) && (off_x < 10'(TILE - INSET)) &&
                   (off_y >= 10'(INSET)) && (off_y < 10'(TILE - INSET));

        if (pix.next_x >= 10'(H_ACTIVE) || pix.next_y >= 10'(V_ACTIVE)) color_next = 8'h00;
        else if (frog_hit)              color_next = FROG_COLOR;
        else if (tile_y == 10'd0)       color_next = GOAL_COLOR;
        else if (tile_y <= 10'd6)       color_next = WATER_COLOR;
        else if (tile_y == 10'd7)       color_next = MEDIAN_COLOR;
        else if (tile_y <= 10'd13)      color_next = ROAD_COLOR;
        else                            color_next = START_COLOR;
    end

    always_ff @(posedge clk_25M) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state        <= IDLE;
            win_pending  <= 1'b0;
            frame_tick   <= 1'b0;
            btn_meta     <= 4'd0;
            btn_sync     <= 4'd0;
            frog_col     <= 5'(START_COL);
            frog_row     <= 4'(START_ROW);
            win          <= 1'b0;
            score        <= 4'd0;
            pix.color_in <= 8'h00;
        end else begin
            btn_meta     <= {btn_up, btn_down, btn_left, btn_right};
            btn_sync     <= btn_meta;
            frame_tick   <= (pix.next_x == 10'd0) && (pix.next_y == 10'(V_ACTIVE));
            win          <= 1'b0;
            pix.color_in <= color_next;

            // Position only moves in vblank, so a rendered frame never shows a torn frog.
            if (frame_tick) begin
                if (win_pending) begin
                    frog_col    <= 5'(START_COL);
                    frog_row    <= 4'(START_ROW);
                    win_pending <= 1'b0;
                    state       <= any_btn ? WAIT_REL : IDLE;
                end else begin
                    case (state)
                        IDLE: begin
                            if (any_btn) begin
                                frog_col <= hop_col;
                                frog_row <= hop_row;
                                state    <= WAIT_REL;
                                if (hop_row == 4'd0) begin
                                    win         <= 1'b1;
                                    score       <= score + 4'd1;
                                    win_pending <= 1'b1;
                                end
                            end
                        end
                        WAIT_REL: begin
                            if (!any_btn) state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_frog_scene_gen.sv
// Self-checking bench for frog_scene_gen: table-driven color vectors, directed hop/win sequences,
// and random button frames compared against a rule-level model.
module tb_frog_scene_gen;
    localparam logic [7:0] FC     = 8'b11111100;
    localparam logic [7:0] GOAL   = 8'b00011100;
    localparam logic [7:0] WATER  = 8'b00000011;
    localparam logic [7:0] MEDIAN = 8'b00010100;
    localparam logic [7:0] ROAD   = 8'b01001001;
    localparam logic [7:0] START  = 8'b00010100;

    logic       clk_25M;
    logic       reset;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic [4:0] frog_col;
    logic [3:0] frog_row;
    logic       win;
    logic [3:0] score;

    frog_scene_gen_if pix ();

    frog_scene_gen dut (
        .clk_25M  (clk_25M),
        .reset    (reset),
        .pix      (pix.slave),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .frog_col (frog_col),
        .frog_row (frog_row),
        .win      (win),
        .score    (score)
    );

    initial clk_25M = 1'b0;
    always #20 clk_25M = ~clk_25M;

    int total = 0;
    int bad   = 0;

    // Rule-level model of the frog game.
    int m_col, m_row, m_score;
    bit m_wait, m_pend, m_win;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] exp;
    } color_vec_t;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] ref_color(input int x, input int y, input int fc, input int fr);
        int tc, tr, ox, oy;
        if (x >= 640 || y >= 480) return 8'h00;
        tc = x / 32; tr = y / 32; ox = x % 32; oy = y % 32;
        if (tc == fc && tr == fr && ox >= 4 && ox < 28 && oy >= 4 && oy < 28) return FC;
        if (tr == 0)  return GOAL;
        if (tr <= 6)  return WATER;
        if (tr == 7)  return MEDIAN;
        if (tr <= 13) return ROAD;
        return START;
    endfunction

    task automatic model_reset();
        m_col = 9; m_row = 14; m_score = 0; m_wait = 0; m_pend = 0; m_win = 0;
    endtask

    task automatic model_frame(input logic [3:0] b);
        m_win = 0;
        if (m_pend) begin
            m_col = 9; m_row = 14; m_pend = 0; m_wait = (b != 4'd0);
        end else if (!m_wait) begin
            if (b != 4'd0) begin
                if (b[3])      m_row = (m_row > 0)  ? m_row - 1 : 0;
                else if (b[2]) m_row = (m_row < 14) ? m_row + 1 : 14;
                else if (b[1]) m_col = (m_col > 0)  ? m_col - 1 : 0;
                else           m_col = (m_col < 19) ? m_col + 1 : 19;
                m_wait = 1;
                if (m_row == 0) begin
                    m_win = 1; m_pend = 1; m_score = (m_score + 1) % 16;
                end
            end
        end else if (b == 4'd0) begin
            m_wait = 0;
        end
    endtask

    task automatic set_btns(input logic [3:0] b);
        btn_up = b[3]; btn_down = b[2]; btn_left = b[1]; btn_right = b[0];
    endtask

    task automatic check_state(input string tag);
        check({tag, ".col"},   int'(frog_col), m_col);
        check({tag, ".row"},   int'(frog_row), m_row);
        check({tag, ".score"}, int'(score),    m_score);
    endtask

    // One vblank: buttons settle through the synchronizer, then a single (0,480) strobe.
    task automatic do_frame(input logic [3:0] b, input string tag);
        @(negedge clk_25M);
        set_btns(b);
        repeat (3) @(negedge clk_25M);
        pix.next_x = 10'd0; pix.next_y = 10'd480;
        @(negedge clk_25M);
        pix.next_x = 10'd1;
        @(negedge clk_25M);
        model_frame(b);
        check_state(tag);
        check({tag, ".win"}, int'(win), int'(m_win));
        @(negedge clk_25M);
        check({tag, ".win_after"}, int'(win), 0);
    endtask

    task automatic press_release(input logic [3:0] b, input string tag);
        do_frame(b, tag);
        do_frame(4'd0, {tag, ".rel"});
    endtask

    task automatic check_color(input int x, input int y, input logic [7:0] exp, input string tag);
        @(negedge clk_25M);
        pix.next_x = 10'(x); pix.next_y = 10'(y);
        @(negedge clk_25M);
        check(tag, int'(pix.color_in), int'(exp));
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk_25M);
        reset = 1'b0;
        repeat (cycles) @(negedge clk_25M);
        reset = 1'b1;
        model_reset();
    endtask

    color_vec_t vecs [12];

    initial begin
        vecs[0]  = '{292, 452, FC};
        vecs[1]  = '{291, 452, START};
        vecs[2]  = '{640, 0,   8'h00};
        vecs[3]  = '{0,   0,   GOAL};
        vecs[4]  = '{0,   32,  WATER};
        vecs[5]  = '{100, 224, MEDIAN};
        vecs[6]  = '{300, 256, ROAD};
        vecs[7]  = '{315, 475, FC};
        vecs[8]  = '{316, 452, START};
        vecs[9]  = '{292, 451, START};
        vecs[10] = '{639, 479, START};
        vecs[11] = '{5,   480, 8'h00};

        reset = 1'b0;
        set_btns(4'd0);
        pix.next_x = 10'd0; pix.next_y = 10'd0;

        // Reset held three cycles, then reset values and the first drawn pixel.
        apply_reset(3);
        check("rst.color", int'(pix.color_in), 0);
        check("rst.win",   int'(win), 0);
        check_state("rst");
        @(negedge clk_25M);
        check("rst.pix00", int'(pix.color_in), int'(GOAL));

        // Held up moves once; a second press moves again.
        do_frame(4'b1000, "hold1");
        do_frame(4'b1000, "hold2");
        do_frame(4'b1000, "hold3");
        do_frame(4'b0000, "hold_rel");
        check("hold.row13", int'(frog_row), 13);
        do_frame(4'b1000, "press2");
        check("press2.row12", int'(frog_row), 12);
        do_frame(4'b0000, "press2_rel");

        // Up and left together only moves vertically.
        press_release(4'b1010, "upleft");
        check("upleft.col", int'(frog_col), 9);

        // Left edge clamp, then a different button while still held must not move.
        for (int i = 0; i < 9; i++) press_release(4'b0010, "to_left");
        do_frame(4'b0010, "left_clamp");
        check("left_clamp.col0", int'(frog_col), 0);
        do_frame(4'b0001, "wait_rel_hold");
        do_frame(4'b0000, "left_rel");
        for (int i = 0; i < 19; i++) press_release(4'b0001, "to_right");
        do_frame(4'b0001, "right_clamp");
        check("right_clamp.col19", int'(frog_col), 19);
        do_frame(4'b0000, "right_rel");

        // Climb to row 0: win pulse, score, then respawn at the next tick.
        while (m_row > 1) press_release(4'b1000, "climb");
        do_frame(4'b1000, "win_hop");
        check("win_hop.pulse", int'(win), 0);
        check("win_hop.score1", int'(score), 1);
        do_frame(4'b0000, "respawn");
        check("respawn.col", int'(frog_col), 9);
        check("respawn.row", int'(frog_row), 14);

        // Color vectors with the frog at its start tile.
        foreach (vecs[i]) check_color(vecs[i].x, vecs[i].y, vecs[i].exp, $sformatf("color_vec%0d", i));

        // Reset while a button is held mid-frame: back to start and IDLE.
        press_release(4'b1000, "pre_rst");
        @(negedge clk_25M);
        set_btns(4'b0100);
        pix.next_x = 10'd100; pix.next_y = 10'd200;
        repeat (4) @(negedge clk_25M);
        apply_reset(2);
        check_state("midrst");
        do_frame(4'b0100, "midrst_idle");
        do_frame(4'b0000, "midrst_rel");
        do_frame(4'b1000, "midrst_up");
        check("midrst_up.row13", int'(frog_row), 13);

        // Random button frames and random pixels against the model.
        for (int i = 0; i < 80; i++) begin
            logic [3:0] b;
            b = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            do_frame(b, $sformatf("rnd%0d", i));
        end
        for (int i = 0; i < 40; i++) begin
            int x, y;
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 524);
            if (x == 0 && y == 480) x = 1;
            check_color(x, y, ref_color(x, y, m_col, m_row), $sformatf("rnd_color%0d", i));
        end
        for (int i = 0; i < 12; i++) begin
            int x, y;
            x = m_col * 32 + $urandom_range(0, 31);
            y = m_row * 32 + $urandom_range(0, 31);
            check_color(x, y, ref_color(x, y, m_col, m_row), $sformatf("frog_color%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
